// File: rtl/wmr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wmr_pkg
// Description : Shared types and widths for the write/read start/finish
//               handshake. Used by both the initiator and the responder.
// Revision    : 1.0 - initial release
// ============================================================================
package wmr_pkg;

  localparam int WMR_ADDR_W = 3;
  localparam int WMR_DATA_W = 32;

  // Initiator handshake phases: accept, request, release, respond.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2,
    ST_RSP  = 2'd3
  } wmr_init_state_t;

endpackage
`default_nettype wire

// File: rtl/wmr_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : wmr_initiator_if
// Description : Command, responder and response bundles of the initiator.
//               master = initiator view, slave = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface wmr_initiator_if;
  import wmr_pkg::*;

  // command port
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wren;
  logic [WMR_ADDR_W-1:0] req_address;
  logic [WMR_DATA_W-1:0] req_wdata;

  // responder side
  logic                  start;
  logic                  wren;
  logic [WMR_ADDR_W-1:0] address;
  logic [WMR_DATA_W-1:0] write_data;
  logic                  finish;
  logic [WMR_DATA_W-1:0] rd_data;

  // response port
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WMR_DATA_W-1:0] rsp_rdata;
  logic                  rsp_error;

  modport master (
    input  req_valid, req_wren, req_address, req_wdata,
    output req_ready,
    output start, wren, address, write_data,
    input  finish, rd_data,
    output rsp_valid, rsp_rdata, rsp_error,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_wren, req_address, req_wdata,
    input  req_ready,
    input  start, wren, address, write_data,
    output finish, rd_data,
    input  rsp_valid, rsp_rdata, rsp_error,
    output rsp_ready
  );

endinterface
`default_nettype wire

// File: rtl/wmr_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wmr_watchdog
// Description : Saturating up-counter measuring cycles spent in a handshake
//               phase. o_expired flags the TIMEOUT_CYCLES-th cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wmr_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_clear,
  input  wire logic i_enable,
  output logic      o_expired
);

  // The count holds the number of cycles already completed in the phase, so
  // it reads TIMEOUT_CYCLES-1 during the TIMEOUT_CYCLES-th cycle.
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_MAX   = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles; clear wins; hold at C_MAX so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != C_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count >= C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/wmr_initiator.sv
`default_nettype none
// ============================================================================
// Module      : wmr_initiator
// Description : Initiator of the start/finish four-phase handshake. Takes one
//               command at a time, drives start/wren/address/write_data,
//               waits for finish to rise and fall, and returns a response.
//               A watchdog aborts REQ or REL when the responder is silent.
// Revision    : 1.0 - initial release
// ============================================================================
module wmr_initiator
  import wmr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input wire logic         clk,
  input wire logic         rst_n,
  wmr_initiator_if.master  bus
);

  wmr_init_state_t r_state;
  wmr_init_state_t w_state_nxt;

  logic                  r_req_ready, w_req_ready_nxt;
  logic                  r_start,     w_start_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic                  r_wren,      w_wren_nxt;
  logic [WMR_ADDR_W-1:0] r_address,   w_address_nxt;
  logic [WMR_DATA_W-1:0] r_wdata,     w_wdata_nxt;
  logic [WMR_DATA_W-1:0] r_rdata,     w_rdata_nxt;
  logic                  r_error,     w_error_nxt;

  logic w_wd_clear;
  logic w_wd_enable;
  logic w_wd_expired;

  wmr_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_enable),
    .o_expired (w_wd_expired)
  );

  // Next-state, field updates and watchdog control for the handshake.
  always_comb begin
    w_state_nxt   = r_state;
    w_wren_nxt    = r_wren;
    w_address_nxt = r_address;
    w_wdata_nxt   = r_wdata;
    w_rdata_nxt   = r_rdata;
    w_error_nxt   = r_error;
    w_wd_clear    = 1'b0;
    w_wd_enable   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_wren_nxt    = bus.req_wren;
          w_address_nxt = bus.req_address;
          w_wdata_nxt   = bus.req_wdata;
          w_wd_clear    = 1'b1;
          w_state_nxt   = ST_REQ;
        end
      end

      ST_REQ: begin
        w_wd_enable = 1'b1;
        // finish is checked first: an ack in the timeout cycle still succeeds
        if (bus.finish) begin
          if (!r_wren) begin
            w_rdata_nxt = bus.rd_data;
          end
          w_wd_clear  = 1'b1;
          w_state_nxt = ST_REL;
        end else if (w_wd_expired) begin
          w_error_nxt = 1'b1;
          w_rdata_nxt = '0;
          w_wd_clear  = 1'b1;
          w_state_nxt = ST_REL;
        end
      end

      ST_REL: begin
        w_wd_enable = 1'b1;
        if (!bus.finish) begin
          w_state_nxt = ST_RSP;
        end else if (w_wd_expired) begin
          // a read captured in REQ is discarded once the release fails
          w_error_nxt = 1'b1;
          w_rdata_nxt = '0;
          w_state_nxt = ST_RSP;
        end
      end

      ST_RSP: begin
        if (bus.rsp_ready) begin
          w_rdata_nxt = '0;
          w_error_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_rdata_nxt = '0;
        w_error_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Handshake outputs are decoded from the next state so they leave flops.
    w_start_nxt     = (w_state_nxt == ST_REQ);
    w_req_ready_nxt = (w_state_nxt == ST_IDLE);
    w_rsp_valid_nxt = (w_state_nxt == ST_RSP);
  end

  // State and output registers; reset drops start immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_wren      <= 1'b0;
      r_address   <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_start     <= w_start_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_wren      <= w_wren_nxt;
      r_address   <= w_address_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.start      = r_start;
  assign bus.wren       = r_wren;
  assign bus.address    = r_address;
  assign bus.write_data = r_wdata;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rdata;
  assign bus.rsp_error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_wmr_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_wmr_initiator
// Description : Directed bench for wmr_initiator with a small responder
//               model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wmr_initiator;

  localparam int TIMEOUT_CYCLES = 8;

  // responder behaviours
  localparam int M_NORMAL = 0;   // finish follows start one cycle later
  localparam int M_TIED0  = 1;   // never answers
  localparam int M_STUCK  = 2;   // answers, then never releases

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   mode;
  logic [31:0] rd_val;

  int checks   = 0;
  int failures = 0;
  int n_rsp    = 0;
  int exp_rsp  = 0;
  exp_t sb[$];

  wmr_initiator_if bus ();

  wmr_initiator #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Responder model with a registered finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.finish <= 1'b0;
    end else begin
      case (mode)
        M_TIED0: bus.finish <= 1'b0;
        M_STUCK: bus.finish <= bus.start | bus.finish;
        default: bus.finish <= bus.start;
      endcase
    end
  end

  // garbage outside finish exposes a capture at the wrong time
  assign bus.rd_data = bus.finish ? rd_val : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
    exp_rsp++;
  endtask

  // Scoreboard monitor: samples just after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        chk("ready_valid_exclusive", 32'(bus.req_ready & bus.rsp_valid), 32'd0);
        if (bus.rsp_valid && bus.rsp_ready) begin
          n_rsp++;
          if (sb.size() == 0) begin
            chk("unexpected_response", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_error", 32'(bus.rsp_error), 32'(e.err));
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a command at a falling edge; returns at the falling edge of the
  // first cycle after acceptance.
  task automatic issue(input logic w, input logic [2:0] a, input logic [31:0] d);
    int b;
    b = 0;
    bus.req_valid   = 1'b1;
    bus.req_wren    = w;
    bus.req_address = a;
    bus.req_wdata   = d;
    while (!bus.req_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("accept_in_time", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while (n_rsp < exp_rsp && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk("response_in_time", 32'(n_rsp >= exp_rsp), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"},  32'(bus.req_ready), 32'd1);
    chk({tag, "_start"},      32'(bus.start),     32'd0);
    chk({tag, "_wren"},       32'(bus.wren),      32'd0);
    chk({tag, "_address"},    32'(bus.address),   32'd0);
    chk({tag, "_write_data"}, bus.write_data,     32'd0);
    chk({tag, "_rsp_valid"},  32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"},  bus.rsp_rdata,      32'd0);
    chk({tag, "_rsp_error"},  32'(bus.rsp_error), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n           = 1'b0;
    mode            = M_NORMAL;
    rd_val          = 32'd0;
    bus.req_valid   = 1'b0;
    bus.req_wren    = 1'b0;
    bus.req_address = 3'd0;
    bus.req_wdata   = 32'd0;
    bus.rsp_ready   = 1'b1;

    wait_cyc(2);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: write, addr 5 -- cycle-exact timing against the registered responder
    chk("w_start_before_accept", 32'(bus.start), 32'd0);
    push_exp(32'd0, 1'b0);
    issue(1'b1, 3'd5, 32'hDEAD_BEEF);
    chk("w_c1_start",      32'(bus.start),     32'd1);
    chk("w_c1_wren",       32'(bus.wren),      32'd1);
    chk("w_c1_address",    32'(bus.address),   32'd5);
    chk("w_c1_write_data", bus.write_data,     32'hDEAD_BEEF);
    chk("w_c1_req_ready",  32'(bus.req_ready), 32'd0);
    wait_cyc(1);
    chk("w_c2_start", 32'(bus.start), 32'd1);
    wait_cyc(1);
    chk("w_c3_start",   32'(bus.start),   32'd0);
    chk("w_c3_address", 32'(bus.address), 32'd5);
    wait_cyc(1);
    chk("w_c4_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    wait_cyc(1);
    chk("w_c5_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    wait_done();
    wait_cyc(1);

    // 2: read, addr 2, captured data
    rd_val = 32'h1234_5678;
    push_exp(32'h1234_5678, 1'b0);
    issue(1'b0, 3'd2, 32'h0);
    wait_done();
    wait_cyc(1);

    // 3: responder silent -- start lasts exactly TIMEOUT_CYCLES
    mode = M_TIED0;
    push_exp(32'd0, 1'b1);
    issue(1'b0, 3'd4, 32'h0);
    chk("t0_c1_start", 32'(bus.start), 32'd1);
    wait_cyc(7);
    chk("t0_c8_start", 32'(bus.start), 32'd1);
    wait_cyc(1);
    chk("t0_c9_start", 32'(bus.start), 32'd0);
    wait_done();
    wait_cyc(1);

    // 4: finish stuck high after ack -- release phase times out
    mode   = M_STUCK;
    rd_val = 32'hAAAA_5555;
    push_exp(32'd0, 1'b1);
    issue(1'b0, 3'd6, 32'h0);
    wait_cyc(9);
    chk("st_c10_start",     32'(bus.start),     32'd0);
    chk("st_c10_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    wait_cyc(1);
    chk("st_c11_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    wait_done();
    mode = M_NORMAL;
    wait_cyc(2);

    // 5: response back-pressure; a new command is ignored meanwhile
    rd_val        = 32'hCAFE_F00D;
    bus.rsp_ready = 1'b0;
    push_exp(32'hCAFE_F00D, 1'b0);
    issue(1'b0, 3'd3, 32'h0);
    wait_cyc(4);
    bus.req_valid   = 1'b1;
    bus.req_wren    = 1'b1;
    bus.req_address = 3'd7;
    bus.req_wdata   = 32'h1111_1111;
    push_exp(32'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_rdata", bus.rsp_rdata,      32'hCAFE_F00D);
      chk("bp_rsp_error", 32'(bus.rsp_error), 32'd0);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_address",   32'(bus.address),   32'd3);
      if (i < 9) @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_req_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_idle_start",     32'(bus.start),     32'd0);
    chk("bp_idle_address",   32'(bus.address),   32'd3);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp_next_start",   32'(bus.start),   32'd1);
    chk("bp_next_address", 32'(bus.address), 32'd7);
    chk("bp_next_wren",    32'(bus.wren),    32'd1);
    wait_done();
    wait_cyc(1);

    // 6: asynchronous reset in REQ, then a normal transaction
    mode = M_TIED0;
    issue(1'b1, 3'd1, 32'h55AA_55AA);
    chk("rst_c1_start", 32'(bus.start), 32'd1);
    wait_cyc(1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    mode  = M_NORMAL;
    @(negedge clk);
    push_exp(32'd0, 1'b0);
    issue(1'b1, 3'd0, 32'h1357_2468);
    chk("after_rst_address",    32'(bus.address), 32'd0);
    chk("after_rst_write_data", bus.write_data,   32'h1357_2468);
    wait_done();
    wait_cyc(2);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wmr_initiator.md
# wmr_initiator

Initiator side of the start/finish four-phase handshake used by the lab4 write/read responder FSM. It accepts one request at a time from a valid/ready command port and drives `start`, `wren`, `address` and `write_data` toward the responder. It waits for `finish`, captures read data, releases `start`, waits for `finish` to drop, then returns a response. A watchdog aborts handshakes whose responder never answers.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in each of REQ and REL before aborting; legal range 1 to 65535.
- `CNT_W`, default $clog2(TIMEOUT_CYCLES+1): watchdog counter width; derived, not overridden.

Ports:
- `clk` input 1: single clock, all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: initiator can accept a request.
- `req_wren` input 1: 1 selects write, 0 selects read.
- `req_address` input 3: responder address.
- `req_wdata` input 32: write data.
- `start` output 1: handshake request to responder.
- `wren` output 1: registered copy of `req_wren`.
- `address` output 3: registered copy of `req_address`.
- `write_data` output 32: registered copy of `req_wdata`.
- `finish` input 1: responder acknowledge.
- `rd_data` input 32: responder read data, valid while `finish` is 1.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts response.
- `rsp_rdata` output 32: captured read data; 0 for writes and errors.
- `rsp_error` output 1: handshake timed out.

## Operation
States: IDLE, REQ, REL, RSP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `wren`/`address`/`write_data`, clear the watchdog, and go to REQ.
- REQ:
  - `start`=1.
  - When `finish`=1: if read, capture `rd_data` into `rsp_rdata`; clear the watchdog; go to REL.
  - When the watchdog reaches TIMEOUT_CYCLES: set the error flag, clear the watchdog, go to REL.
- REL:
  - `start`=0.
  - When `finish`=0, go to RSP.
  - When the watchdog reaches TIMEOUT_CYCLES, set the error flag and go to RSP.
- RSP:
  - `rsp_valid`=1, holding `rsp_rdata`/`rsp_error` stable.
  - On `rsp_ready`, clear the flags and go to IDLE.
- Any undefined state encoding goes to IDLE.

Field rules:
- `wren`/`address`/`write_data` are stable from REQ entry until the next accepted request.
- These fields change only in IDLE on acceptance.
- On error, `rsp_rdata` is forced to 0.
- A `finish` that rises in the same cycle as a timeout is treated as success: `finish` has priority over the watchdog.
- The watchdog saturates and never wraps.
- `req_valid` is ignored outside IDLE. No queuing; the requester must hold the request until `req_ready`.

## Timing
- Reset: IDLE.
  - `req_ready`=1.
  - `start`=0, `wren`=0, `address`=0, `write_data`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0.
  - Watchdog=0.
- Reset asserted mid-handshake drops `start` asynchronously. The responder then returns to its wait state.
- All outputs are registered.
  - `start` rises the cycle after acceptance.
  - `start` falls the cycle after `finish` is sampled high.
- Against a responder with 1-cycle registered `finish`, the sequence is:
  - acceptance at cycle 0;
  - `start` high cycles 1–2;
  - `finish` high cycles 2–3;
  - `rsp_valid` at cycle 5.
- Back-to-back throughput: one transaction per 6 cycles when `rsp_ready` is held at 1.
- `req_ready` and `rsp_valid` are never both 1.

## Structure
- Shared package `wmr_pkg` holds:
  - the state enum `wmr_init_state_t` (IDLE, REQ, REL, RSP);
  - `WMR_ADDR_W`=3 and `WMR_DATA_W`=32;
  - this package is reused by the responder.
- One sub-module, `wmr_watchdog`: a saturating up-counter with `clear`, `enable` and an `expired` compare against TIMEOUT_CYCLES.

## Test plan
- Write, addr 5, data 0xDEADBEEF, with a responder model:
  - `start` asserts 1 cycle after acceptance, with the fields stable;
  - `rsp_valid` at cycle 5;
  - `rsp_error`=0, `rsp_rdata`=0.
- Read, addr 2, responder drives `rd_data`=0x12345678 while `finish`=1:
  - `rsp_rdata`=0x12345678, `rsp_error`=0.
- `finish` tied 0, TIMEOUT_CYCLES=8:
  - `start` high for exactly 8 cycles, then drops;
  - `rsp_error`=1, `rsp_rdata`=0.
- `finish` stuck 1 after the ack:
  - REL times out after 8 cycles;
  - `rsp_error`=1.
- `rsp_ready` held 0 for 10 cycles:
  - `rsp_valid` and its data stay stable;
  - `req_ready`=0;
  - a new `req_valid` is ignored until one cycle after `rsp_ready`.
- `rst_n` pulsed low while in REQ:
  - `start` drops in the same cycle;
  - all outputs return to their reset values;
  - the next request completes normally.
